// File: rtl/prod_accum_stream_if.sv
// rtl/prod_accum_stream_if.sv - product input stream and group-sum output stream of prod_accum_stream
interface prod_accum_stream_if #(
    parameter int PW = 16,
    parameter int CW = 4,
    parameter int AW = 19
);
    logic          in_valid;
    logic          in_ready;
    logic [PW-1:0] in_prod;
    logic          in_last;
    logic          out_valid;
    logic          out_ready;
    logic [AW-1:0] out_sum;
    logic [CW-1:0] out_cnt;

    // Producer of products and consumer of sums
    modport master (
        output in_valid,
        output in_prod,
        output in_last,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_cnt
    );

    // The accumulator itself
    modport slave (
        input  in_valid,
        input  in_prod,
        input  in_last,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_cnt
    );
endinterface

// File: rtl/prod_accum_stream.sv
// rtl/prod_accum_stream.sv - sums groups of multiplier products into dot-product results; optional input skid via PROD_ACC_INREG_EN
module prod_accum_stream #(
    parameter int PW      = 16,
    parameter int N_TERMS = 8,
    parameter int CW      = 4,
    parameter int AW      = 19
) (
    input  logic                  clk,
    input  logic                  rst_n,
    prod_accum_stream_if.slave    bus
);

    localparam logic [0:0] ST_ACC  = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    // Term stream as seen by the adder (either the raw input or the skid head)
    logic          term_valid;
    logic          term_ready;
    logic [PW-1:0] term_prod;
    logic          term_last;

    logic [0:0]    state;
    logic [AW-1:0] acc;
    logic [CW-1:0] cnt;
    logic [AW-1:0] out_sum_r;
    logic [CW-1:0] out_cnt_r;

    logic          accept;
    logic          handshake;
    logic          closing;
    logic [AW-1:0] sum_next;
    logic [CW-1:0] cnt_next;

`ifdef PROD_ACC_INREG_EN
    // Two entries are enough to keep one term per cycle flowing while
    // in_ready only depends on local state, not on out_ready.
    logic [PW-1:0] skid_prod [2];
    logic [1:0]    skid_last;
    logic          wr_ptr;
    logic          rd_ptr;
    logic [1:0]    skid_count;
    logic          skid_push;
    logic          skid_pop;

    assign bus.in_ready = (skid_count != 2'd2);
    assign skid_push    = bus.in_valid & bus.in_ready;
    assign skid_pop     = term_valid & term_ready;
    assign term_valid   = (skid_count != 2'd0);
    assign term_prod    = skid_prod[rd_ptr];
    assign term_last    = skid_last[rd_ptr];

    // Skid storage: written at the tail, no reset needed for the payload
    always_ff @(posedge clk) begin
        if (skid_push) begin
            skid_prod[wr_ptr] <= bus.in_prod;
            skid_last[wr_ptr] <= bus.in_last;
        end
    end

    // Skid pointers and occupancy; reset empties the skid
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr     <= 1'b0;
            rd_ptr     <= 1'b0;
            skid_count <= 2'd0;
        end else begin
            if (skid_push) begin
                wr_ptr <= ~wr_ptr;
            end
            if (skid_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({skid_push, skid_pop})
                2'b10:   skid_count <= skid_count + 2'd1;
                2'b01:   skid_count <= skid_count - 2'd1;
                default: skid_count <= skid_count;
            endcase
        end
    end
`else
    // No skid: in HOLD, in_ready is combinationally out_ready so a
    // back-to-back stream never loses a cycle at group boundaries.
    assign term_valid   = bus.in_valid;
    assign term_prod    = bus.in_prod;
    assign term_last    = bus.in_last;
    assign bus.in_ready = term_ready;
`endif

    // In HOLD a new term may only enter in the same cycle the pending
    // result leaves, so the output register is never overwritten early.
    assign term_ready = (state == ST_ACC) | bus.out_ready;
    assign accept     = term_valid & term_ready;
    assign handshake  = (state == ST_HOLD) & bus.out_ready;

    // acc and cnt are zero whenever state is HOLD, so the same adder
    // serves both a continuing group and the first term of a new one.
    assign sum_next = acc + {{(AW-PW){1'b0}}, term_prod};
    assign cnt_next = cnt + CW'(1);
    assign closing  = term_last | (cnt == CW'(N_TERMS - 1));

    // Group accumulation, result capture and ACC/HOLD control
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state     <= ST_ACC;
            acc       <= '0;
            cnt       <= '0;
            out_sum_r <= '0;
            out_cnt_r <= '0;
        end else if (accept) begin
            if (closing) begin
                out_sum_r <= sum_next;
                out_cnt_r <= cnt_next;
                acc       <= '0;
                cnt       <= '0;
                state     <= ST_HOLD;
            end else begin
                acc       <= sum_next;
                cnt       <= cnt_next;
                state     <= ST_ACC;
            end
        end else if (handshake) begin
            state <= ST_ACC;
        end
    end

    assign bus.out_valid = (state == ST_HOLD);
    assign bus.out_sum   = out_sum_r;
    assign bus.out_cnt   = out_cnt_r;

endmodule

// File: tb/tb_prod_accum_stream.sv
// tb/tb_prod_accum_stream.sv - self-checking bench for prod_accum_stream
module tb_prod_accum_stream;

`ifdef PROD_ACC_INREG_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    prod_accum_stream_if #(.PW(16), .CW(4), .AW(19)) bus ();

    prod_accum_stream #(.PW(16), .N_TERMS(8), .CW(4), .AW(19)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #5000000;
        $display("FAIL watchdog: simulation did not finish, checks=%0d errors=%0d", checks, errors);
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [7:0][15:0] prods;   // term j is prods[j]
        int               n;
        logic             last;    // assert in_last on the final term
        logic [18:0]      exp_sum;
        logic [3:0]       exp_cnt;
    } vec_t;

    vec_t vecs [7];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic push(input logic [15:0] p, input logic l);
        int k;
        bus.in_valid = 1'b1;
        bus.in_prod  = p;
        bus.in_last  = l;
        k = 0;
        @(negedge clk);
        while (!bus.in_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.in_ready) chk("push_timeout", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        bus.in_last  = 1'b0;
    endtask

    task automatic collect(output logic [18:0] s, output logic [3:0] c);
        int k;
        bus.out_ready = 1'b1;
        k = 0;
        @(negedge clk);
        while (!bus.out_valid && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!bus.out_valid) chk("collect_timeout", 32'(bus.out_valid), 32'd1);
        s = bus.out_sum;
        c = bus.out_cnt;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    logic [18:0] got_sum;
    logic [3:0]  got_cnt;
    int unsigned exp_q_sum [$];
    int unsigned exp_q_cnt [$];
    int unsigned cur_sum;
    int unsigned cur_n;
    int          sent;
    int          cyc;
    int          outs;
    int          lat;
    logic        acc_now;
    logic        hs_now;
    logic [7:0]  ma;
    logic [7:0]  mb;

    initial begin
        checks = 0;
        errors = 0;
        bus.in_valid  = 1'b0;
        bus.in_prod   = '0;
        bus.in_last   = 1'b0;
        bus.out_ready = 1'b0;

        vecs[0] = '{prods: {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd7, 16'd5, 16'd3}, n: 3, last: 1'b1, exp_sum: 19'd15, exp_cnt: 4'd3};
        vecs[1] = '{prods: {16'd8, 16'd7, 16'd6, 16'd5, 16'd4, 16'd3, 16'd2, 16'd1}, n: 8, last: 1'b0, exp_sum: 19'd36, exp_cnt: 4'd8};
        vecs[2] = '{prods: {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd42}, n: 1, last: 1'b1, exp_sum: 19'd42, exp_cnt: 4'd1};
        vecs[3] = '{prods: {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd0}, n: 2, last: 1'b1, exp_sum: 19'd0, exp_cnt: 4'd2};
        vecs[4] = '{prods: {16'd0, 16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000, 16'd1000}, n: 7, last: 1'b1, exp_sum: 19'd7000, exp_cnt: 4'd7};
        vecs[5] = '{prods: {16'd0, 16'd0, 16'd0, 16'd0, 16'd0, 16'd1, 16'hFFFF, 16'hFFFF}, n: 3, last: 1'b1, exp_sum: 19'h1FFFF, exp_cnt: 4'd3};
        vecs[6] = '{prods: {16'd16, 16'd14, 16'd12, 16'd10, 16'd8, 16'd6, 16'd4, 16'd2}, n: 8, last: 1'b1, exp_sum: 19'd72, exp_cnt: 4'd8};

        // Reset
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("reset_out_valid", 32'(bus.out_valid), 32'd0);
        chk("reset_out_sum", 32'(bus.out_sum), 32'd0);
        chk("reset_out_cnt", 32'(bus.out_cnt), 32'd0);
        chk("reset_in_ready", 32'(bus.in_ready), 32'd1);
        @(posedge clk);
        #1;

        // Full group of maximum products, back to back, sink always ready
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            bus.in_valid = 1'b1;
            bus.in_prod  = 16'hFFFF;
            bus.in_last  = 1'b0;
            @(negedge clk);
            chk($sformatf("full_no_stall_%0d", i), 32'(bus.in_ready), 32'd1);
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        lat = 0;
        for (int k = 1; k <= 6; k++) begin
            @(negedge clk);
            if (bus.out_valid && lat == 0) lat = k;
            if (lat != 0) break;
        end
        chk("full_latency", 32'(lat), 32'(LAT));
        chk("full_sum", 32'(bus.out_sum), 32'h7FFF8);
        chk("full_cnt", 32'(bus.out_cnt), 32'd8);
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("full_released", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;

        // Table-driven groups
        for (int v = 0; v < 7; v++) begin
            for (int j = 0; j < vecs[v].n; j++) begin
                push(vecs[v].prods[j], vecs[v].last && (j == vecs[v].n - 1));
            end
            collect(got_sum, got_cnt);
            chk($sformatf("vec%0d_sum", v), 32'(got_sum), 32'(vecs[v].exp_sum));
            chk($sformatf("vec%0d_cnt", v), 32'(got_cnt), 32'(vecs[v].exp_cnt));
        end

        // Backpressure: hold the result, then restart with 9 during the handshake
        push(16'd3, 1'b0);
        push(16'd5, 1'b0);
        push(16'd7, 1'b1);
        lat = 0;
        while (!bus.out_valid && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk($sformatf("bp_valid_%0d", i), 32'(bus.out_valid), 32'd1);
            chk($sformatf("bp_sum_%0d", i), 32'(bus.out_sum), 32'd15);
            chk($sformatf("bp_in_ready_%0d", i), 32'(bus.in_ready), (LAT == 1) ? 32'd0 : 32'd1);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b1;
        push(16'd9, 1'b0);
        bus.out_ready = 1'b0;
        @(negedge clk);
        chk("bp_after_handshake", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 7; i++) push(16'd1, 1'b0);
        collect(got_sum, got_cnt);
        chk("bp_next_sum", 32'(got_sum), 32'd16);
        chk("bp_next_cnt", 32'(got_cnt), 32'd8);

        // Reset mid-group discards the partial sum
        for (int i = 0; i < 4; i++) push(16'd100, 1'b0);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        chk("midreset_out_valid", 32'(bus.out_valid), 32'd0);
        @(posedge clk);
        #1;
        for (int i = 0; i < 8; i++) push(16'd1, 1'b0);
        collect(got_sum, got_cnt);
        chk("midreset_sum", 32'(got_sum), 32'd8);
        chk("midreset_cnt", 32'(got_cnt), 32'd8);

        // Random traffic from the exact 8x8 multiplier against a group scoreboard
        cur_sum = 0;
        cur_n   = 0;
        sent    = 0;
        cyc     = 0;
        outs    = 0;
        while (sent < 10000 && cyc < 60000) begin
            ma = 8'($urandom);
            mb = 8'($urandom);
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.in_prod   = 16'(ma) * 16'(mb);
            bus.in_last   = ($urandom_range(0, 7) == 0);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            @(negedge clk);
            acc_now = bus.in_valid & bus.in_ready;
            hs_now  = bus.out_valid & bus.out_ready;
`ifndef PROD_ACC_INREG_EN
            chk("rnd_in_ready_rule", 32'(bus.in_ready), 32'(!bus.out_valid || bus.out_ready));
`endif
            if (hs_now) begin
                outs++;
                if (exp_q_sum.size() == 0) begin
                    chk("rnd_unexpected_output", 32'd1, 32'd0);
                end else begin
                    chk("rnd_sum", 32'(bus.out_sum), exp_q_sum.pop_front());
                    chk("rnd_cnt", 32'(bus.out_cnt), exp_q_cnt.pop_front());
                end
            end
            if (acc_now) begin
                sent++;
                cur_sum += 32'(bus.in_prod);
                cur_n++;
                if (cur_n == 8 || bus.in_last) begin
                    exp_q_sum.push_back(cur_sum);
                    exp_q_cnt.push_back(cur_n);
                    cur_sum = 0;
                    cur_n   = 0;
                end
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        chk("rnd_products_sent", 32'(sent), 32'd10000);

        // Drain pending results
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (bus.out_valid) begin
                outs++;
                if (exp_q_sum.size() == 0) begin
                    chk("drain_unexpected_output", 32'd1, 32'd0);
                end else begin
                    chk("drain_sum", 32'(bus.out_sum), exp_q_sum.pop_front());
                    chk("drain_cnt", 32'(bus.out_cnt), exp_q_cnt.pop_front());
                end
            end
            @(posedge clk);
            #1;
        end
        chk("drain_queue_empty", 32'(exp_q_sum.size()), 32'd0);
        chk("rnd_outputs_seen", 32'(outs > 1000), 32'd1);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
